// File: rtl/cdb_pkg.sv
// Shared constants, default widths and helpers for the CDB result arbiter.
package cdb_pkg;

  localparam int NUM_SRC_DEF = 3;
  localparam int DATA_W_DEF  = 16;
  localparam int REG_W_DEF   = 3;
  localparam int ADDR_W_DEF  = 6;
  localparam int DEPTH_DEF   = 2;

  localparam logic KIND_REG   = 1'b0;
  localparam logic KIND_STORE = 1'b1;

  typedef struct packed {
    logic                  kind;
    logic [REG_W_DEF-1:0]  dest;
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] addr;
  } cdb_entry_t;

  // Round-robin successor of idx among n sources (n <= 8), wrapping n-1 -> 0.
  function automatic logic [2:0] rrNext(input logic [2:0] idx, input logic [3:0] n);
    logic [2:0] lastIdx;
    lastIdx = 3'(n - 4'd1);
    if (idx == lastIdx) begin
      return 3'd0;
    end else begin
      return idx + 3'd1;
    end
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: circular FIFO with a registered ready flag
// (ready never reflects a same-cycle pop, so there is no pass-through path).
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 26
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         ready,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     memR [DEPTH];
  logic [PTR_W-1:0] wrPtrR;
  logic [PTR_W-1:0] rdPtrR;
  logic [CNT_W-1:0] countR;
  logic [CNT_W-1:0] countNext;
  logic             readyR;
  logic             doPush;
  logic             doPop;

  assign doPush = push & readyR;
  assign doPop  = pop & (countR != {CNT_W{1'b0}});

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    countNext = countR;
    case ({doPush, doPop})
      2'b10:   countNext = countR + CNT_W'(1);
      2'b01:   countNext = countR - CNT_W'(1);
      default: countNext = countR;
    endcase
  end

  // Storage, pointers, occupancy and the ready flag derived from next occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        memR[i] <= '0;
      end
      wrPtrR <= '0;
      rdPtrR <= '0;
      countR <= '0;
      readyR <= 1'b0;
    end else begin
      if (doPush) begin
        memR[wrPtrR] <= wdata;
        wrPtrR       <= wrPtrR + PTR_W'(1);
      end
      if (doPop) begin
        rdPtrR <= rdPtrR + PTR_W'(1);
      end
      countR <= countNext;
      readyR <= (countNext != CNT_W'(DEPTH));
    end
  end

  assign rdata = memR[rdPtrR];
  assign ready = readyR;
  assign empty = (countR == {CNT_W{1'b0}});

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus result arbiter: buffers per-source results and broadcasts one
// per cycle, round-robin, also driving the register-file and store write ports.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC-1:0]         src_kind,
  input  logic [NUM_SRC*REG_W-1:0]   src_dest,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
  output logic                       cdb_valid,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src,
  output logic                       cdb_kind,
  output logic [REG_W-1:0]           cdb_dest,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       rf_we,
  output logic [REG_W-1:0]           rf_addr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata
);

  localparam int SRC_W = $clog2(NUM_SRC);

  typedef struct packed {
    logic              kind;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t             entryIn  [NUM_SRC];
  entry_t             headOut  [NUM_SRC];
  logic [NUM_SRC-1:0] pushVec;
  logic [NUM_SRC-1:0] popVec;
  logic [NUM_SRC-1:0] readyVec;
  logic [NUM_SRC-1:0] emptyVec;
  logic [NUM_SRC-1:0] notEmpty;

  logic               grantFound;
  logic [SRC_W-1:0]   grantIdx;
  logic [SRC_W-1:0]   cand;
  entry_t             grantEntry;

  logic               cdbValidR;
  logic [SRC_W-1:0]   cdbSrcR;
  logic [SRC_W-1:0]   lastGrantR;
  entry_t             entryR;
  logic               rfWeR;
  logic               memWeR;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    assign entryIn[i] = '{kind: src_kind[i],
                          dest: src_dest[i*REG_W +: REG_W],
                          data: src_data[i*DATA_W +: DATA_W],
                          addr: src_addr[i*ADDR_W +: ADDR_W]};
    assign pushVec[i] = src_valid[i] & readyVec[i];

    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) uFifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (pushVec[i]),
      .pop     (popVec[i]),
      .wdata   (entryIn[i]),
      .rdata   (headOut[i]),
      .ready   (readyVec[i]),
      .empty   (emptyVec[i])
    );
  end

  assign notEmpty  = ~emptyVec;
  assign src_ready = readyVec;

  // Round-robin pick: first non-empty source after the last granted one.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = lastGrantR;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SRC_W'(rrNext(3'(cand), 4'(NUM_SRC)));
      if (!grantFound && notEmpty[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end else begin
        grantFound = grantFound;
      end
    end
  end

  // One-hot pop towards the winning FIFO and the entry it presents.
  always_comb begin
    popVec     = '0;
    grantEntry = headOut[grantIdx];
    if (grantFound) begin
      popVec[grantIdx] = 1'b1;
    end else begin
      popVec = '0;
    end
  end

  // Broadcast register: every bus and write-port output comes from here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdbValidR  <= 1'b0;
      cdbSrcR    <= '0;
      lastGrantR <= SRC_W'(NUM_SRC - 1);
      entryR     <= '0;
      rfWeR      <= 1'b0;
      memWeR     <= 1'b0;
    end else begin
      cdbValidR <= grantFound;
      if (grantFound) begin
        lastGrantR <= grantIdx;
        cdbSrcR    <= grantIdx;
        entryR     <= grantEntry;
        // A tag-0 register result still broadcasts to wake waiters but writes nothing.
        rfWeR      <= (grantEntry.kind == KIND_REG) && (grantEntry.dest != {REG_W{1'b0}});
        memWeR     <= (grantEntry.kind == KIND_STORE);
      end else begin
        rfWeR  <= 1'b0;
        memWeR <= 1'b0;
      end
    end
  end

  assign cdb_valid = cdbValidR;
  assign cdb_src   = cdbSrcR;
  assign cdb_kind  = entryR.kind;
  assign cdb_dest  = entryR.dest;
  assign cdb_data  = entryR.data;
  assign rf_we     = rfWeR;
  assign rf_addr   = entryR.dest;
  assign rf_wdata  = entryR.data;
  assign mem_we    = memWeR;
  assign mem_addr  = entryR.addr;
  assign mem_wdata = entryR.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model of the broadcast rules.
module tb_cdb_arbiter;

  localparam int NS = 3;
  localparam int DP = 2;

  logic        clock;
  logic        reset_n;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [2:0]  src_kind;
  logic [8:0]  src_dest;
  logic [47:0] src_data;
  logic [17:0] src_addr;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic        cdb_kind;
  logic [2:0]  cdb_dest;
  logic [15:0] cdb_data;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wdata;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;

  cdb_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_kind(src_kind),
    .src_dest(src_dest), .src_data(src_data), .src_addr(src_addr),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_kind(cdb_kind),
    .cdb_dest(cdb_dest), .cdb_data(cdb_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          kind;
    logic [2:0]  dest;
    logic [15:0] data;
    logic [5:0]  addr;
  } res_t;

  res_t q0[$], q1[$], q2[$];
  int   lastG;
  bit   readyExp [NS];
  bit   accepted [NS];
  bit   expValid;
  int   expSrc;
  res_t expEnt;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
  endfunction

  task automatic resetModel();
    q0.delete(); q1.delete(); q2.delete();
    lastG    = NS - 1;
    expValid = 1'b0;
    expSrc   = 0;
    expEnt   = '{kind: 1'b0, dest: 3'd0, data: 16'h0000, addr: 6'd0};
    for (int i = 0; i < NS; i++) begin
      readyExp[i] = 1'b0;
      accepted[i] = 1'b0;
    end
  endtask

  // Reference behaviour at a rising edge: grant from pre-edge contents, then enqueue.
  task automatic modelEdge();
    bit found;
    int g;
    res_t r;
    found = 1'b0;
    g = 0;
    for (int off = 1; off <= NS; off++) begin
      int c;
      c = (lastG + off) % NS;
      if (!found && qsize(c) > 0) begin
        found = 1'b1;
        g = c;
      end
    end
    for (int i = 0; i < NS; i++) accepted[i] = src_valid[i] && readyExp[i];
    expValid = found;
    if (found) begin
      expSrc = g;
      lastG  = g;
      if (g == 0) expEnt = q0.pop_front();
      else if (g == 1) expEnt = q1.pop_front();
      else expEnt = q2.pop_front();
    end
    for (int i = 0; i < NS; i++) begin
      if (accepted[i]) begin
        r.kind = src_kind[i];
        r.dest = src_dest[i*3 +: 3];
        r.data = src_data[i*16 +: 16];
        r.addr = src_addr[i*6 +: 6];
        if (i == 0) q0.push_back(r);
        else if (i == 1) q1.push_back(r);
        else q2.push_back(r);
      end
    end
    for (int i = 0; i < NS; i++) readyExp[i] = (qsize(i) != DP);
  endtask

  task automatic checkOut();
    logic [2:0] rdy;
    bit wantRf, wantMem;
    rdy = {readyExp[2], readyExp[1], readyExp[0]};
    wantRf  = expValid && !expEnt.kind && (expEnt.dest != 3'd0);
    wantMem = expValid && expEnt.kind;
    chk("src_ready", 32'(src_ready), 32'(rdy));
    chk("cdb_valid", 32'(cdb_valid), 32'(expValid));
    chk("rf_we", 32'(rf_we), 32'(wantRf));
    chk("mem_we", 32'(mem_we), 32'(wantMem));
    if (expValid) begin
      chk("cdb_src", 32'(cdb_src), 32'(expSrc));
      chk("cdb_kind", 32'(cdb_kind), 32'(expEnt.kind));
      chk("cdb_dest", 32'(cdb_dest), 32'(expEnt.dest));
      chk("cdb_data", 32'(cdb_data), 32'(expEnt.data));
    end
    if (wantRf) begin
      chk("rf_addr", 32'(rf_addr), 32'(expEnt.dest));
      chk("rf_wdata", 32'(rf_wdata), 32'(expEnt.data));
    end
    if (wantMem) begin
      chk("mem_addr", 32'(mem_addr), 32'(expEnt.addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(expEnt.data));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOut();
  endtask

  task automatic setSrc(input int i, input bit v, input bit k, input logic [2:0] d,
                        input logic [15:0] x, input logic [5:0] a);
    src_valid[i]        = v;
    src_kind[i]         = k;
    src_dest[i*3 +: 3]  = d;
    src_data[i*16 +: 16] = x;
    src_addr[i*6 +: 6]  = a;
  endtask

  task automatic idleAll();
    src_valid = 3'b000;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_valid"}, 32'(cdb_valid), 32'd0);
    chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_data"}, 32'(cdb_data), 32'd0);
    chk({tag, "_src"}, 32'(cdb_src), 32'd0);
    chk({tag, "_ready"}, 32'(src_ready), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("rst");
    idleAll();
    resetModel();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int rot;
    int pushed;
    int budget;
    clock = 1'b0;
    reset_n = 1'b0;
    src_valid = '0; src_kind = '0; src_dest = '0; src_data = '0; src_addr = '0;
    resetModel();

    // Reset state and release.
    #12 checkResetOutputs("por");
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(src_ready), 32'h7);

    // Single register write from source 1.
    setSrc(1, 1'b1, 1'b0, 3'd3, 16'h00A5, 6'd0);
    tick();
    idleAll();
    tick();
    chk("wr_valid", 32'(cdb_valid), 32'd1);
    chk("wr_src", 32'(cdb_src), 32'd1);
    chk("wr_rf_we", 32'(rf_we), 32'd1);
    chk("wr_rf_addr", 32'(rf_addr), 32'd3);
    chk("wr_rf_wdata", 32'(rf_wdata), 32'h00A5);
    chk("wr_mem_we", 32'(mem_we), 32'd0);

    // Store from source 2.
    setSrc(2, 1'b1, 1'b1, 3'd5, 16'h1234, 6'd10);
    tick();
    idleAll();
    tick();
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", 32'(mem_addr), 32'd10);
    chk("st_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("st_rf_we", 32'(rf_we), 32'd0);

    // Register result to tag 0: broadcast without a register write.
    setSrc(0, 1'b1, 1'b0, 3'd0, 16'hBEEF, 6'd0);
    tick();
    idleAll();
    tick();
    chk("d0_valid", 32'(cdb_valid), 32'd1);
    chk("d0_rf_we", 32'(rf_we), 32'd0);
    tick();

    // Fairness: every source offers continuously from reset.
    doReset();
    rot = 0;
    for (int n = 0; n < 15; n++) begin
      for (int i = 0; i < NS; i++)
        setSrc(i, 1'b1, 1'b0, 3'(i + 1), 16'((i << 12) | n), 6'd0);
      tick();
      if (expValid) begin
        chk("fair_src", 32'(cdb_src), 32'(rot));
        rot = (rot + 1) % NS;
      end
    end

    // Backpressure: source 0 offers three entries while 1 and 2 stay busy.
    idleAll();
    repeat (8) tick();
    pushed = 0;
    budget = 0;
    setSrc(1, 1'b1, 1'b1, 3'd2, 16'h1111, 6'd1);
    setSrc(2, 1'b1, 1'b0, 3'd4, 16'h2222, 6'd2);
    while (pushed < 3 && budget < 30) begin
      setSrc(0, 1'b1, 1'b0, 3'd6, 16'hC000 + 16'(pushed), 6'd0);
      tick();
      if (accepted[0]) pushed++;
      budget++;
    end
    chk("bp_pushed", 32'(pushed), 32'd3);
    idleAll();
    repeat (8) tick();

    // Mid-operation reset with two entries still buffered.
    for (int i = 0; i < NS; i++) setSrc(i, 1'b1, 1'b0, 3'(i + 1), 16'hD000 + 16'(i), 6'd0);
    tick();
    idleAll();
    tick();
    chk("pre_rst_valid", 32'(cdb_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("async_rst");
    resetModel();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin
      tick();
      chk("no_stale", 32'(cdb_valid), 32'd0);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++)
        setSrc(i, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 16'($urandom), 6'($urandom_range(0, 63)));
      tick();
    end
    idleAll();
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
